// File: rtl/tb_cmd_executor.sv
// Command executor: responder end of the sequencer's valid/ack command interface.
// Executes one decoded command at a time against the DUT pins and tallies check failures.
module tb_cmd_executor #(
    parameter int                 DATA_W   = 16,
    parameter int                 TIMEOUT  = 1000,
    parameter logic [DATA_W-1:0]  DRV_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [4:0]        cmd_sel,
    input  logic [31:0]       cmd_data,
    output logic              cmd_ack,
    output logic              busy,
    output logic [DATA_W-1:0] drv_out,
    input  logic [DATA_W-1:0] mon_in,
    output logic [7:0]        err_cnt,
    output logic              test_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_WAIT, S_ACK, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_WAIT_CYC = 3'd1,
        OP_SET      = 3'd2,
        OP_SETB     = 3'd3,
        OP_WAIT_EQ  = 3'd4,
        OP_CHECK    = 3'd5,
        OP_END_TEST = 3'd6,
        OP_ILLEGAL  = 3'd7
    } op_t;

    localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

    state_t            r_state;
    state_t            w_next_state;
    op_t               r_op;
    logic [4:0]        r_sel;
    logic [31:0]       r_data;
    logic [31:0]       r_cnt;
    logic [DATA_W-1:0] r_drv;
    logic [7:0]        r_err_cnt;

    logic              w_match;
    logic              w_sel_bad;
    logic              w_err_inc;
    logic [DATA_W-1:0] w_setb_val;

    // Only the low DATA_W bits of the argument take part in compares.
    assign w_match   = (mon_in == r_data[DATA_W-1:0]);
    assign w_sel_bad = ({27'd0, r_sel} >= 32'(DATA_W));

    always_comb begin
        w_setb_val = r_drv;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_sel == 5'(i)) begin
                w_setb_val[i] = r_data[0];
            end
        end
    end

    always_comb begin
        w_err_inc = 1'b0;
        if (r_state == S_EXEC) begin
            case (r_op)
                OP_CHECK:   w_err_inc = !w_match;
                OP_SETB:    w_err_inc = w_sel_bad;
                OP_ILLEGAL: w_err_inc = 1'b1;
                default:    w_err_inc = 1'b0;
            endcase
        end else if (r_state == S_WAIT && r_op == OP_WAIT_EQ) begin
            // A match on the last counted cycle wins over the timeout.
            w_err_inc = !w_match && (r_cnt == 32'd1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next_state = S_EXEC;
            end
            S_EXEC: begin
                case (r_op)
                    OP_WAIT_CYC: w_next_state = (r_data == 32'd0) ? S_ACK : S_WAIT;
                    OP_WAIT_EQ:  w_next_state = w_match ? S_ACK : S_WAIT;
                    default:     w_next_state = S_ACK;
                endcase
            end
            S_WAIT: begin
                if (r_op == OP_WAIT_EQ) begin
                    if (w_match || r_cnt == 32'd1) w_next_state = S_ACK;
                end else if (r_cnt == 32'd1) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK:   w_next_state = (r_op == OP_END_TEST) ? S_DONE : S_IDLE;
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ack   = 1'b0;
        busy      = 1'b0;
        test_done = 1'b0;
        case (r_state)
            S_EXEC, S_WAIT: busy = 1'b1;
            S_ACK: begin
                busy    = 1'b1;
                cmd_ack = 1'b1;
            end
            S_DONE:  test_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_NOP;
            r_sel     <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_drv     <= DRV_INIT;
            r_err_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_op   <= op_t'(cmd_op);
                r_sel  <= cmd_sel;
                r_data <= cmd_data;
            end

            if (r_state == S_EXEC) begin
                case (r_op)
                    OP_SET:      r_drv <= r_data[DATA_W-1:0];
                    OP_SETB:     if (!w_sel_bad) r_drv <= w_setb_val;
                    OP_WAIT_CYC: r_cnt <= r_data;
                    OP_WAIT_EQ:  r_cnt <= TIMEOUT_CNT;
                    default:     ;
                endcase
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 32'd1;
            end

            // Saturate rather than wrap so a long failing run stays visible.
            if (w_err_inc && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign drv_out = r_drv;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_tb_cmd_executor.sv
// Directed bench for tb_cmd_executor: ack latency, drive/compare results and error counting.
// A second instance with TIMEOUT=8 covers the WAIT_EQ timeout path.
module tb_tb_cmd_executor;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_a = 1'b0;
    logic          valid_b = 1'b0;
    logic [2:0]    op = '0;
    logic [4:0]    sel = '0;
    logic [31:0]   data = '0;
    logic [DW-1:0] mon = '0;

    logic          ack_a, busy_a, done_a;
    logic [DW-1:0] drv_a;
    logic [7:0]    err_a;
    logic          ack_b, busy_b, done_b;
    logic [DW-1:0] drv_b;
    logic [7:0]    err_b;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int acks;

    always #5 clk = ~clk;

    tb_cmd_executor #(.DATA_W(DW), .TIMEOUT(1000), .DRV_INIT('0)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_op(op), .cmd_sel(sel),
        .cmd_data(data), .cmd_ack(ack_a), .busy(busy_a), .drv_out(drv_a),
        .mon_in(mon), .err_cnt(err_a), .test_done(done_a)
    );

    tb_cmd_executor #(.DATA_W(DW), .TIMEOUT(8), .DRV_INIT('0)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_op(op), .cmd_sel(sel),
        .cmd_data(data), .cmd_ack(ack_b), .busy(busy_b), .drv_out(drv_b),
        .mon_in(mon), .err_cnt(err_b), .test_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present a command, hold it until ack; lat = cycles from capture edge to ack (-1 if none).
    task automatic issue(input bit use_b, input logic [2:0] o, input logic [4:0] s,
                         input logic [31:0] d, output int l);
        @(negedge clk);
        op   = o;
        sel  = s;
        data = d;
        if (use_b) valid_b = 1'b1;
        else       valid_a = 1'b1;
        @(posedge clk);
        l = -1;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if ((use_b ? ack_b : ack_a) === 1'b1) begin
                l = k;
                break;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ack",  {31'd0, ack_a},  32'd0);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_drv",  {16'd0, drv_a},  32'd0);
        check("reset_err",  {24'd0, err_a},  32'd0);
        check("reset_done", {31'd0, done_a}, 32'd0);

        issue(1'b0, 3'd2, 5'd0, 32'h0000_00A5, lat);
        check("set_lat",  lat, 32'd2);
        check("set_drv",  {16'd0, drv_a}, 32'h00A5);
        check("set_busy_in_ack", {31'd0, busy_a}, 32'd1);
        check("set_err",  {24'd0, err_a}, 32'd0);

        issue(1'b0, 3'd1, 5'd0, 32'd5, lat);
        check("wait_cyc5_lat", lat, 32'd7);
        issue(1'b0, 3'd1, 5'd0, 32'd0, lat);
        check("wait_cyc0_lat", lat, 32'd2);

        fork
            issue(1'b0, 3'd4, 5'd0, 32'h0000_1234, lat);
            begin
                @(negedge clk);
                @(posedge clk);
                repeat (10) @(posedge clk);
                #1 mon = 16'h1234;
            end
        join
        check("wait_eq_lat", lat, 32'd12);
        check("wait_eq_err", {24'd0, err_a}, 32'd0);

        mon = 16'h0000;
        issue(1'b1, 3'd4, 5'd0, 32'h0000_1234, lat);
        check("wait_eq_timeout_lat", lat, 32'd10);
        check("wait_eq_timeout_err", {24'd0, err_b}, 32'd1);

        mon = 16'h000E;
        for (int i = 1; i <= 300; i++) begin
            issue(1'b0, 3'd5, 5'd0, 32'h0000_000F, lat);
            if (i == 1)   check("check_fail_first", {24'd0, err_a}, 32'd1);
            if (i == 255) check("check_reach_255", {24'd0, err_a}, 32'd255);
        end
        check("check_saturated", {24'd0, err_a}, 32'd255);
        mon = 16'h000F;
        issue(1'b0, 3'd5, 5'd0, 32'h0000_000F, lat);
        check("check_pass_lat", lat, 32'd2);
        check("check_pass_holds_255", {24'd0, err_a}, 32'd255);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_err", {24'd0, err_a}, 32'd0);
        check("rst2_drv", {16'd0, drv_a}, 32'd0);

        issue(1'b0, 3'd3, 5'd3, 32'd1, lat);
        check("setb3_lat", lat, 32'd2);
        check("setb3_drv", {16'd0, drv_a}, 32'h0008);
        issue(1'b0, 3'd3, 5'd20, 32'd1, lat);
        check("setb20_drv", {16'd0, drv_a}, 32'h0008);
        check("setb20_err", {24'd0, err_a}, 32'd1);
        issue(1'b0, 3'd7, 5'd0, 32'd0, lat);
        check("illegal_lat", lat, 32'd2);
        check("illegal_err", {24'd0, err_a}, 32'd2);

        @(negedge clk);
        op      = 3'd1;
        data    = 32'd100;
        valid_a = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrst_busy_before", {31'd0, busy_a}, 32'd1);
        rst     = 1'b1;
        valid_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ack",  {31'd0, ack_a},  32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_drv",  {16'd0, drv_a},  32'd0);
        check("midrst_err",  {24'd0, err_a},  32'd0);
        check("midrst_done", {31'd0, done_a}, 32'd0);
        acks = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) acks++;
        end
        check("midrst_no_ack", acks, 32'd0);

        issue(1'b0, 3'd6, 5'd0, 32'd0, lat);
        check("end_lat", lat, 32'd2);
        @(negedge clk);
        check("end_done", {31'd0, done_a}, 32'd1);
        check("end_busy", {31'd0, busy_a}, 32'd0);
        op      = 3'd0;
        valid_a = 1'b1;
        acks    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) acks++;
        end
        valid_a = 1'b0;
        check("done_no_ack", acks, 32'd0);
        check("done_sticky", {31'd0, done_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
